// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if: requester handshake and SPI-master control bundle for the arbiter.
// master is the arbiter side; slave is the requesters/SPI-master side.
interface spi_bus_arbiter_if;
    logic [2:0]  req_i;
    logic [2:0]  req_nrw_i;
    logic [23:0] req_len_i;
    logic [2:0]  gnt_o;
    logic [2:0]  done_o;
    logic [2:0]  err_o;
    logic [2:0]  spi_sel_o;
    logic        spi_start_o;
    logic        spi_nrw_o;
    logic [7:0]  spi_len_o;
    logic        spi_done_i;
    logic        bus_idle_o;
    modport master (
        input  req_i, req_nrw_i, req_len_i, spi_done_i,
        output gnt_o, done_o, err_o, spi_sel_o, spi_start_o, spi_nrw_o, spi_len_o, bus_idle_o
    );
    modport slave (
        output req_i, req_nrw_i, req_len_i, spi_done_i,
        input  gnt_o, done_o, err_o, spi_sel_o, spi_start_o, spi_nrw_o, spi_len_o, bus_idle_o
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin arbiter granting one of three requesters an SPI master,
// with chip-select setup, start pulse, completion/timeout wait and a guard gap.
module spi_bus_arbiter #(
    parameter int unsigned GUARD_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    spi_bus_arbiter_if.master  bus
);
    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, GUARD} state_t;
    state_t      state_q, state_d;
    logic [1:0]  last_q, last_d, cur_q, cur_d, p0, p1, win;
    logic        nrw_q, nrw_d;
    logic [7:0]  len_q, len_d, win_len;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  done_q, done_d, err_q, err_d, sel;
    // Search order starts just after the last winner; last_q itself is the lowest priority.
    always_comb begin
        p0      = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
        p1      = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
        win     = bus.req_i[p0] ? p0 : bus.req_i[p1] ? p1 : last_q;
        win_len = bus.req_len_i[{win, 3'b000} +: 8];
        sel     = (state_q == SETUP || state_q == START || state_q == WAIT) ? 3'b001 << cur_q : 3'b000;
    end
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cur_d   = cur_q;
        nrw_d   = nrw_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            IDLE: if (|bus.req_i) begin
                last_d = win;
                if (win_len == 8'd0) begin
                    err_d = 3'b001 << win;
                end else begin
                    state_d = SETUP;
                    cur_d   = win;
                    nrw_d   = bus.req_nrw_i[win];
                    len_d   = win_len;
                end
            end
            SETUP: state_d = START;
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            // Completion takes precedence over a timeout landing in the same cycle.
            WAIT: if (bus.spi_done_i || cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                state_d = GUARD;
                cnt_d   = 16'(GUARD_CYCLES - 1);
                done_d  = bus.spi_done_i ? sel : 3'b000;
                err_d   = bus.spi_done_i ? 3'b000 : sel;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            GUARD: if (cnt_q == 16'd0) state_d = IDLE;
                   else cnt_d = cnt_q - 16'd1;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 2'd2;
            cur_q   <= 2'd0;
            nrw_q   <= 1'b0;
            len_q   <= 8'd0;
            cnt_q   <= 16'd0;
            done_q  <= 3'b000;
            err_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            nrw_q   <= nrw_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign bus.gnt_o       = sel;
    assign bus.spi_sel_o   = sel;
    assign bus.spi_start_o = state_q == START;
    assign bus.spi_nrw_o   = nrw_q;
    assign bus.spi_len_o   = len_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.bus_idle_o  = state_q == IDLE;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed stimulus with a cycle-stamped event scoreboard
// for select rises, start, done and error pulses of spi_bus_arbiter.
module tb_spi_bus_arbiter;
    localparam int K_SEL = 0, K_START = 1, K_DONE = 2, K_ERR = 3;
    typedef struct {int kind; logic [2:0] val; int cyc;} ev_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [2:0] prev_sel = 3'b000;
    ev_t exp_q[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    spi_bus_arbiter_if bus();
    spi_bus_arbiter dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(int kind, logic [2:0] val, int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(int kind, logic [2:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d val=%b cycle=%0d", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
                errors++;
                $display("FAIL event got kind=%0d val=%b cycle=%0d expected kind=%0d val=%b cycle=%0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    task automatic to_cyc(int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("sel_eq_gnt_onehot", {30'b0, bus.spi_sel_o == bus.gnt_o, $onehot0(bus.spi_sel_o)}, 32'h3);
            if (bus.spi_sel_o != 3'b000 && prev_sel == 3'b000) observe(K_SEL, bus.spi_sel_o);
            if (bus.spi_start_o) observe(K_START, bus.spi_sel_o);
            if (bus.done_o != 3'b000) observe(K_DONE, bus.done_o);
            if (bus.err_o != 3'b000) observe(K_ERR, bus.err_o);
        end
        prev_sel = rst ? 3'b000 : bus.spi_sel_o;
    end

    initial begin
        int c;
        logic [2:0] g;
        bus.req_i      = 3'b000;
        bus.req_nrw_i  = 3'b000;
        bus.req_len_i  = 24'h0;
        bus.spi_done_i = 1'b0;
        to_cyc(3);
        chk("rst_idle", bus.bus_idle_o, 1);
        chk("rst_sel", bus.spi_sel_o, 0);
        chk("rst_gnt", bus.gnt_o, 0);
        chk("rst_start", bus.spi_start_o, 0);
        chk("rst_nrw", bus.spi_nrw_o, 0);
        chk("rst_len", bus.spi_len_o, 0);
        chk("rst_done_err", {bus.done_o, bus.err_o}, 0);
        rst = 1'b0;
        to_cyc(5);

        // contention: flash, shift reg, MPU, flash; 7-cycle period with guard gap
        c = cyc;
        bus.req_i     = 3'b111;
        bus.req_nrw_i = 3'b010;
        bus.req_len_i = {8'd6, 8'd5, 8'd4};
        for (int i = 0; i < 4; i++) begin
            g = 3'b001 << (i % 3);
            push(K_SEL, g, c + 1 + 7 * i);
            push(K_START, g, c + 2 + 7 * i);
            push(K_DONE, g, c + 5 + 7 * i);
        end
        for (int i = 0; i < 4; i++) begin
            to_cyc(c + 2 + 7 * i);
            if (i == 3) bus.req_i = 3'b000;
            chk("cont_len", bus.spi_len_o, 4 + i % 3);
            chk("cont_nrw", bus.spi_nrw_o, i == 1 ? 1 : 0);
            to_cyc(c + 4 + 7 * i);
            bus.spi_done_i = 1'b1;
            to_cyc(c + 5 + 7 * i);
            bus.spi_done_i = 1'b0;
            chk("cont_guard_sel", bus.spi_sel_o, 0);
        end
        to_cyc(c + 35);

        // single flash write, done at start+9; spi_done_i during SETUP is ignored
        c = cyc;
        bus.req_i     = 3'b001;
        bus.req_nrw_i = 3'b001;
        bus.req_len_i = 24'h000008;
        push(K_SEL, 3'b001, c + 1);
        push(K_START, 3'b001, c + 2);
        push(K_DONE, 3'b001, c + 12);
        to_cyc(c + 1);
        bus.req_i = 3'b000;
        bus.spi_done_i = 1'b1;
        to_cyc(c + 2);
        bus.spi_done_i = 1'b0;
        to_cyc(c + 5);
        chk("wr_nrw", bus.spi_nrw_o, 1);
        chk("wr_len", bus.spi_len_o, 8);
        to_cyc(c + 11);
        bus.spi_done_i = 1'b1;
        to_cyc(c + 12);
        bus.spi_done_i = 1'b0;
        chk("wr_guard0_idle", bus.bus_idle_o, 0);
        to_cyc(c + 13);
        chk("wr_guard1_idle", bus.bus_idle_o, 0);
        chk("wr_guard1_sel", bus.spi_sel_o, 0);
        to_cyc(c + 14);
        chk("wr_back_idle", bus.bus_idle_o, 1);
        to_cyc(c + 18);

        // zero-length shift-register request
        c = cyc;
        bus.req_i     = 3'b010;
        bus.req_len_i = 24'h0;
        push(K_ERR, 3'b010, c + 1);
        to_cyc(c + 1);
        bus.req_i = 3'b000;
        chk("zl_idle0", bus.bus_idle_o, 1);
        to_cyc(c + 2);
        chk("zl_idle1", bus.bus_idle_o, 1);
        chk("zl_sel", bus.spi_sel_o, 0);
        to_cyc(c + 5);

        // MPU timeout
        c = cyc;
        bus.req_i     = 3'b100;
        bus.req_nrw_i = 3'b100;
        bus.req_len_i = {8'd16, 16'd0};
        push(K_SEL, 3'b100, c + 1);
        push(K_START, 3'b100, c + 2);
        push(K_ERR, 3'b100, c + 1027);
        to_cyc(c + 1);
        bus.req_i = 3'b000;
        to_cyc(c + 1026);
        chk("to_sel_held", bus.spi_sel_o, 3'b100);
        to_cyc(c + 1027);
        chk("to_sel_clr", bus.spi_sel_o, 0);
        chk("to_no_done", bus.done_o, 0);
        to_cyc(c + 1029);
        chk("to_idle", bus.bus_idle_o, 1);
        to_cyc(c + 1032);

        // done on the timeout cycle
        c = cyc;
        bus.req_i     = 3'b001;
        bus.req_len_i = 24'h000008;
        push(K_SEL, 3'b001, c + 1);
        push(K_START, 3'b001, c + 2);
        push(K_DONE, 3'b001, c + 1027);
        to_cyc(c + 1);
        bus.req_i = 3'b000;
        to_cyc(c + 1026);
        bus.spi_done_i = 1'b1;
        to_cyc(c + 1027);
        bus.spi_done_i = 1'b0;
        chk("coll_err", bus.err_o, 0);
        to_cyc(c + 1032);

        // reset during WAIT, then flash wins a full request
        c = cyc;
        bus.req_i     = 3'b010;
        bus.req_len_i = 24'h000800;
        push(K_SEL, 3'b010, c + 1);
        push(K_START, 3'b010, c + 2);
        to_cyc(c + 1);
        bus.req_i = 3'b000;
        to_cyc(c + 5);
        chk("rw_sel_before", bus.spi_sel_o, 3'b010);
        rst = 1'b1;
        #1;
        chk("rw_sel_async", bus.spi_sel_o, 0);
        chk("rw_gnt_async", bus.gnt_o, 0);
        to_cyc(c + 7);
        chk("rw_done_err", {bus.done_o, bus.err_o}, 0);
        chk("rw_len", bus.spi_len_o, 0);
        chk("rw_idle", bus.bus_idle_o, 1);
        rst = 1'b0;
        to_cyc(c + 9);
        c = cyc;
        bus.req_i     = 3'b111;
        bus.req_len_i = {8'd3, 8'd2, 8'd1};
        push(K_SEL, 3'b001, c + 1);
        push(K_START, 3'b001, c + 2);
        push(K_DONE, 3'b001, c + 4);
        to_cyc(c + 1);
        bus.req_i = 3'b000;
        to_cyc(c + 3);
        bus.spi_done_i = 1'b1;
        to_cyc(c + 4);
        bus.spi_done_i = 1'b0;
        to_cyc(c + 10);

        chk("events_pending", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter GUARD_CYCLES, default 2: idle cycles with all selects low between transactions; legal range 1..15.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles in WAIT before abort; legal range 16..65535.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset; asynchronous assert, active-high, released synchronously to clk_i.
REQ-005 req_i  input  3  per-requester transaction request, level: bit0 = flash, bit1 = shift register, bit2 = MPU.
REQ-006 req_nrw_i  input  3  per-requester direction: 0 = read, 1 = write.
REQ-007 req_len_i  input  24  per-requester bit count, 8 bits each; requester k uses bits [8k+7:8k].
REQ-008 gnt_o  output  3  one-hot grant, held from SETUP through WAIT.
REQ-009 done_o  output  3  one-cycle completion pulse to the granted requester.
REQ-010 err_o  output  3  one-cycle error pulse: zero-length request or timeout.
REQ-011 spi_sel_o  output  3  one-hot chip-select enable to the SPI master (flash, shift reg, MPU).
REQ-012 spi_start_o  output  1  one-cycle start pulse to the SPI master.
REQ-013 spi_nrw_o  output  1  latched direction of the current transaction.
REQ-014 spi_len_o  output  8  latched bit count of the current transaction.
REQ-015 spi_done_i  input  1  one-cycle transfer-complete pulse from the SPI master.
REQ-016 bus_idle_o  output  1  high only in IDLE.

Function
REQ-017 States: IDLE, SETUP, START, WAIT, GUARD; encoding is free.
REQ-018 IDLE: when any req_i bit is high, the arbiter selects a winner, latches its nrw/len and moves to SETUP on the next edge.
REQ-019 Arbitration: round-robin; the search starts at (last_grant+1) mod 3; last_grant resets to 2, so flash wins first.
REQ-020 Zero-length winner (len = 0): the arbiter pulses err_o[k] for one cycle, updates last_grant, stays in IDLE and asserts no select.
REQ-021 SETUP (1 cycle): gnt_o[k] and spi_sel_o[k] are high, giving chip-select setup time; the next state is START.
REQ-022 START (1 cycle): spi_start_o = 1 and sel/gnt are held; the next state is WAIT.
REQ-023 Latency: req_i seen in IDLE at cycle N gives sel at N+1 and spi_start_o at N+2.
REQ-024 WAIT: sel/gnt are held and a cycle counter runs; spi_done_i moves the FSM to GUARD.
REQ-025 On the spi_done_i edge, the arbiter pulses done_o[k] for one cycle, clears gnt_o and spi_sel_o, and loads the guard counter.
REQ-026 Timeout: when TIMEOUT_CYCLES elapse in WAIT without spi_done_i, the arbiter pulses err_o[k], clears sel/gnt and enters GUARD; done_o is not pulsed.
REQ-027 If spi_done_i and timeout occur in the same cycle, done wins and no err is pulsed.
REQ-028 GUARD: all selects stay low for exactly GUARD_CYCLES, then the FSM returns to IDLE; requests during GUARD are held off.
REQ-029 Dropping req_k after grant has no effect; the transaction runs to done or timeout.
REQ-030 spi_done_i outside WAIT is ignored.
REQ-031 spi_sel_o and gnt_o are never multi-hot; spi_nrw_o and spi_len_o stay stable from SETUP through WAIT.
REQ-032 A requester that keeps req_i high after done gets re-granted only after other pending requesters (fairness).

Reset
REQ-033 While rst_i is high: state = IDLE; gnt_o, done_o, err_o, spi_sel_o = 0; spi_start_o = 0; spi_nrw_o = 0; spi_len_o = 0; bus_idle_o = 1; last_grant = 2; counters = 0.
REQ-034 Reset asserted mid-transaction drops spi_sel_o in the same cycle (asynchronously) and pulses no done_o or err_o.

Verification
REQ-035 Single flash write: req_i = 001, nrw = 1, len = 8, spi_done_i at start+9 -> sel 001 at N+1, start at N+2, done_o = 001 one cycle, sel low for 2 cycles.
REQ-036 Contention: req_i = 111 held -> grant order flash, shift reg, MPU, flash, with ≥2 idle-select cycles between grants.
REQ-037 Zero length: req_i = 010, len = 0 -> err_o = 010 for one cycle, spi_start_o never asserted, bus_idle_o stays 1.
REQ-038 Timeout: MPU request, spi_done_i withheld -> err_o = 100 exactly 1024 cycles after entering WAIT, sel cleared, then IDLE.
REQ-039 Reset in WAIT: rst_i pulse -> sel/gnt 0 immediately, no done/err pulse; after release, flash wins the next 111 request.
REQ-040 Collision: spi_done_i on the timeout cycle -> done_o pulsed, err_o stays 0.
